// File: rtl/a2d_spi_master_if.sv
// Request/result handshake with the motion controller plus the SPI pins to the ADC128S.
// The master modport is the converter's view; slave is the controller/ADC side.
interface a2d_spi_master_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        a2d_SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport master (
    input  strt_cnv, chnnl, MISO,
    output cnv_cmplt, res, a2d_SS_n, SCLK, MOSI
  );

  modport slave (
    output strt_cnv, chnnl, MISO,
    input  cnv_cmplt, res, a2d_SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/a2d_spi_master.sv
// A2D conversion engine: two 16-bit SPI frames to an ADC128S at clk/32, the second
// frame's low 12 bits become the published result.
module a2d_spi_master (
  input  logic              clk,
  input  logic              rst_n,
  a2d_spi_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, FRAME1, GAP, FRAME2, DONE} state_t;

  state_t      state_r, state_s;
  logic [2:0]  chnnl_r, chnnl_s;
  logic [15:0] tx_r, tx_s;
  logic [15:0] rx_r, rx_s;
  logic [4:0]  div_r, div_s;
  logic [4:0]  bit_cnt_r, bit_cnt_s;
  logic        ss_n_r, ss_n_s;
  logic        sclk_r, sclk_s;
  logic        cmplt_r, cmplt_s;
  logic [11:0] res_r, res_s;
  logic [4:0]  div_inc_s;

  assign div_inc_s     = div_r + 5'd1;
  assign bus.a2d_SS_n  = ss_n_r;
  assign bus.SCLK      = sclk_r;
  assign bus.MOSI      = tx_r[15];
  assign bus.cnv_cmplt = cmplt_r;
  assign bus.res       = res_r;

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      chnnl_r   <= 3'd0;
      tx_r      <= 16'h0000;
      rx_r      <= 16'h0000;
      div_r     <= 5'b10110;
      bit_cnt_r <= 5'd0;
      ss_n_r    <= 1'b1;
      sclk_r    <= 1'b1;
      cmplt_r   <= 1'b0;
      res_r     <= 12'h000;
    end else begin
      state_r   <= state_s;
      chnnl_r   <= chnnl_s;
      tx_r      <= tx_s;
      rx_r      <= rx_s;
      div_r     <= div_s;
      bit_cnt_r <= bit_cnt_s;
      ss_n_r    <= ss_n_s;
      sclk_r    <= sclk_s;
      cmplt_r   <= cmplt_s;
      res_r     <= res_s;
    end
  end

  // Next-state and next-register values for the conversion sequence.
  always_comb begin
    state_s   = state_r;
    chnnl_s   = chnnl_r;
    tx_s      = tx_r;
    rx_s      = rx_r;
    div_s     = div_r;
    bit_cnt_s = bit_cnt_r;
    ss_n_s    = ss_n_r;
    sclk_s    = sclk_r;
    cmplt_s   = cmplt_r;
    res_s     = res_r;

    case (state_r)
      IDLE: begin
        ss_n_s = 1'b1;
        sclk_s = 1'b1;
        if (bus.strt_cnv) begin
          chnnl_s = bus.chnnl;
          tx_s    = {2'b00, bus.chnnl, 11'h000};
          div_s   = 5'd22;
          cmplt_s = 1'b0;
          ss_n_s  = 1'b0;
          state_s = FRAME1;
        end else begin
          state_s = IDLE;
        end
      end

      FRAME1, FRAME2: begin
        div_s  = div_inc_s;
        sclk_s = div_inc_s[4];
        // The first fall of a frame leaves bit 15 on MOSI for the first rise.
        if ((div_r == 5'd31) && (bit_cnt_r != 5'd0)) begin
          tx_s = {tx_r[14:0], 1'b0};
        end else begin
          tx_s = tx_r;
        end
        if (div_r == 5'd15) begin
          rx_s      = {rx_r[14:0], bus.MISO};
          bit_cnt_s = bit_cnt_r + 5'd1;
        end else begin
          rx_s      = rx_r;
        end
        if ((bit_cnt_r == 5'd16) && (div_inc_s == 5'd30)) begin
          ss_n_s    = 1'b1;
          sclk_s    = 1'b1;
          bit_cnt_s = 5'd0;
          state_s   = (state_r == FRAME1) ? GAP : DONE;
        end else begin
          ss_n_s    = 1'b0;
        end
      end

      GAP: begin
        // Divider runs 30 -> 31 -> reload, giving exactly two clocks of SS_n high.
        div_s  = div_inc_s;
        ss_n_s = 1'b1;
        sclk_s = 1'b1;
        if (div_r == 5'd31) begin
          tx_s    = {2'b00, chnnl_r, 11'h000};
          div_s   = 5'd22;
          ss_n_s  = 1'b0;
          state_s = FRAME2;
        end else begin
          state_s = GAP;
        end
      end

      DONE: begin
        ss_n_s  = 1'b1;
        sclk_s  = 1'b1;
        res_s   = rx_r[11:0];
        cmplt_s = 1'b1;
        state_s = IDLE;
      end

      default: begin
        ss_n_s  = 1'b1;
        sclk_s  = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_a2d_spi_master.sv
// Directed bench for a2d_spi_master with a behavioural ADC128S that answers
// each frame with the value of the channel addressed in the previous frame.
module tb_a2d_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  a2d_spi_master_if bus ();

  a2d_spi_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] adc_val [8];
  initial begin
    adc_val[0] = 12'h012; adc_val[1] = 12'h1F3; adc_val[2] = 12'h2C4; adc_val[3] = 12'h3B5;
    adc_val[4] = 12'h4A6; adc_val[5] = 12'hA5C; adc_val[6] = 12'h6E7; adc_val[7] = 12'h7FF;
  end

  // ADC model and SPI monitor, evaluated away from the active clock edge.
  int          fall_q[$], rise_q[$], frame_rises[$];
  logic [15:0] frame_mosi[$];
  logic        ss_prev = 1'b1, sclk_prev = 1'b1;
  logic [15:0] adc_word = 16'h0000, mosi_word = 16'h0000;
  logic [2:0]  cur_addr = 3'd0;
  int          adc_fall = 0, rise_cnt = 0, miso_t = 0, sclk_bad = 0, setup_bad = 0;

  always @(negedge clk) begin
    if (ss_prev && !bus.a2d_SS_n) begin
      fall_q.push_back(cyc);
      adc_fall  = 0;
      rise_cnt  = 0;
      mosi_word = 16'h0000;
      adc_word  = {4'hB, adc_val[cur_addr]};
    end
    if (!ss_prev && bus.a2d_SS_n) begin
      rise_q.push_back(cyc);
      frame_rises.push_back(rise_cnt);
      frame_mosi.push_back(mosi_word);
      cur_addr = mosi_word[13:11];
    end
    if (bus.a2d_SS_n && ss_prev && (bus.SCLK !== sclk_prev)) sclk_bad++;
    if (!bus.a2d_SS_n) begin
      if (sclk_prev && !bus.SCLK && adc_fall < 16) begin
        bus.MISO = adc_word[4'(15 - adc_fall)];
        miso_t   = cyc;
        adc_fall++;
      end
      if (!sclk_prev && bus.SCLK) begin
        if (cyc - miso_t < 15) setup_bad++;
        rise_cnt++;
        mosi_word = {mosi_word[14:0], bus.MOSI};
      end
    end else begin
      bus.MISO = 1'b0;
    end
    ss_prev   = bus.a2d_SS_n;
    sclk_prev = bus.SCLK;
  end

  task automatic clear_mon();
    fall_q.delete(); rise_q.delete(); frame_rises.delete(); frame_mosi.delete();
    sclk_bad = 0; setup_bad = 0;
  endtask

  task automatic start_conv(input logic [2:0] ch, output int t0);
    @(negedge clk);
    bus.strt_cnv = 1'b1;
    bus.chnnl    = ch;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.strt_cnv = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (bus.cnv_cmplt === 1'b1) begin
        dc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.strt_cnv = 1'b0; bus.chnnl = 3'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.a2d_SS_n !== 1'b1) begin bad++; $display("FAIL reset_ss got=%b exp=1", bus.a2d_SS_n); end
    total++; if (bus.SCLK !== 1'b1) begin bad++; $display("FAIL reset_sclk got=%b exp=1", bus.SCLK); end
    total++; if (bus.cnv_cmplt !== 1'b0) begin bad++; $display("FAIL reset_cmplt got=%b exp=0", bus.cnv_cmplt); end
    total++; if (bus.res !== 12'h000) begin bad++; $display("FAIL reset_res got=%h exp=000", bus.res); end
    total++; if (bus.MOSI !== 1'b0) begin bad++; $display("FAIL reset_mosi got=%b exp=0", bus.MOSI); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int t0, dc;
    clear_mon();
    start_conv(3'd5, t0);
    wait_done(dc);
    total++; if (dc != t0 + 1043) begin bad++; $display("FAIL basic_done_cyc got=%0d exp=%0d", dc - t0, 1043); end
    total++; if (bus.res !== 12'hA5C) begin bad++; $display("FAIL basic_res got=%h exp=a5c", bus.res); end
    total++;
    if (fall_q.size() != 2 || rise_q.size() != 2) begin
      bad++; $display("FAIL basic_ss_edges got=%0d/%0d exp=2/2", fall_q.size(), rise_q.size());
    end else if (fall_q[0] != t0 || rise_q[0] != t0 + 520 || fall_q[1] != t0 + 522 || rise_q[1] != t0 + 1042) begin
      bad++; $display("FAIL basic_ss_timing got=%0d,%0d,%0d,%0d exp=0,520,522,1042",
                      fall_q[0] - t0, rise_q[0] - t0, fall_q[1] - t0, rise_q[1] - t0);
    end
    total++;
    if (frame_mosi.size() != 2) begin
      bad++; $display("FAIL basic_mosi_frames got=%0d exp=2", frame_mosi.size());
    end else if (frame_mosi[0] !== 16'h2800 || frame_mosi[1] !== 16'h2800) begin
      bad++; $display("FAIL basic_mosi got=%h,%h exp=2800,2800", frame_mosi[0], frame_mosi[1]);
    end
  endtask

  task automatic test_sweep();
    logic [2:0] order [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    int t0, dc;
    clear_mon();
    for (int k = 0; k < 6; k++) begin
      start_conv(order[k], t0);
      total++; if (bus.cnv_cmplt !== 1'b0) begin bad++; $display("FAIL sweep_cmplt_clear ch=%0d got=%b exp=0", order[k], bus.cnv_cmplt); end
      wait_done(dc);
      total++; if (bus.res !== adc_val[order[k]] || dc != t0 + 1043) begin
        bad++; $display("FAIL sweep_res ch=%0d got=%h@%0d exp=%h@1043", order[k], bus.res, dc - t0, adc_val[order[k]]);
      end
    end
  endtask

  task automatic test_spi_timing();
    int t0, dc, ok;
    clear_mon();
    start_conv(3'd6, t0);
    wait_done(dc);
    repeat (10) @(negedge clk);
    ok = (frame_rises.size() == 2) ? 1 : 0;
    total++; if (ok == 0 || frame_rises[0] != 16 || frame_rises[1] != 16) begin
      bad++; $display("FAIL timing_rises frames=%0d exp=2 with 16 rises each", frame_rises.size());
    end
    total++; if (sclk_bad != 0) begin bad++; $display("FAIL timing_sclk_idle got=%0d exp=0", sclk_bad); end
    total++; if (setup_bad != 0) begin bad++; $display("FAIL timing_setup got=%0d exp=0", setup_bad); end
    total++; if (bus.res !== 12'h6E7) begin bad++; $display("FAIL timing_res got=%h exp=6e7", bus.res); end
  endtask

  task automatic test_ignore_strt();
    int t0, dc;
    clear_mon();
    start_conv(3'd2, t0);
    while (cyc < t0 + 300) @(negedge clk);
    bus.strt_cnv = 1'b1; bus.chnnl = 3'd7;
    @(posedge clk); #1;
    bus.strt_cnv = 1'b0;
    total++; if (bus.a2d_SS_n !== 1'b0 || bus.cnv_cmplt !== 1'b0) begin
      bad++; $display("FAIL ignore_midframe got ss=%b cmplt=%b exp ss=0 cmplt=0", bus.a2d_SS_n, bus.cnv_cmplt);
    end
    wait_done(dc);
    total++; if (bus.res !== 12'h2C4 || dc != t0 + 1043) begin
      bad++; $display("FAIL ignore_res got=%h@%0d exp=2c4@1043", bus.res, dc - t0);
    end
    repeat (60) @(negedge clk);
    total++; if (fall_q.size() != 2) begin bad++; $display("FAIL ignore_no_restart got=%0d frames exp=2", fall_q.size()); end
    total++; if (frame_mosi.size() != 2 || frame_mosi[1] !== 16'h1000) begin
      bad++; $display("FAIL ignore_mosi got frames=%0d exp=2 with 1000", frame_mosi.size());
    end
  endtask

  task automatic test_reset_mid();
    int t0, dc;
    start_conv(3'd6, t0);
    while (cyc < t0 + 700) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.a2d_SS_n !== 1'b1 || bus.SCLK !== 1'b1) begin
      bad++; $display("FAIL rstmid_pins got ss=%b sclk=%b exp 1 1", bus.a2d_SS_n, bus.SCLK);
    end
    total++; if (bus.cnv_cmplt !== 1'b0 || bus.res !== 12'h000) begin
      bad++; $display("FAIL rstmid_result got cmplt=%b res=%h exp 0 000", bus.cnv_cmplt, bus.res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    start_conv(3'd3, t0);
    wait_done(dc);
    total++; if (bus.res !== 12'h3B5 || dc != t0 + 1043) begin
      bad++; $display("FAIL rstmid_after got=%h@%0d exp=3b5@1043", bus.res, dc - t0);
    end
  endtask

  task automatic test_back_to_back();
    int t0, dc, changed;
    // Previous conversion just completed; request in the first IDLE cycle after DONE.
    bus.strt_cnv = 1'b1; bus.chnnl = 3'd4;
    @(posedge clk); #1;
    t0 = cyc;
    bus.strt_cnv = 1'b0;
    total++; if (bus.a2d_SS_n !== 1'b0 || bus.cnv_cmplt !== 1'b0) begin
      bad++; $display("FAIL b2b_accept got ss=%b cmplt=%b exp 0 0", bus.a2d_SS_n, bus.cnv_cmplt);
    end
    changed = 0;
    dc = -1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (bus.cnv_cmplt === 1'b1) begin dc = cyc; break; end
      if (bus.res !== 12'h3B5) changed++;
    end
    total++; if (changed != 0) begin bad++; $display("FAIL b2b_res_held got=%0d changes exp=0", changed); end
    total++; if (bus.res !== 12'h4A6 || dc != t0 + 1043) begin
      bad++; $display("FAIL b2b_res got=%h@%0d exp=4a6@1043", bus.res, dc - t0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_spi_timing();
    test_ignore_strt();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
